// File: rtl/typepkg.sv
// Shared types and constants for the OAM DMA arbiter.
//   dma_state_t   : arbiter FSM state encoding
//   DMA_TRIG_ADDR : CPU write address that starts a DMA transfer
//   OAM_DATA_ADDR : destination address every DMA byte is written to
package typepkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_ALIGN,
      ST_READ,
      ST_WRITE
   } dma_state_t;

   localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares the system bus between the CPU and a 256-byte
// sprite DMA engine. A CPU write of a page number to DMA_TRIG_ADDR halts
// the CPU and copies {page,00}..{page,FF} to OAM_DATA_ADDR, one Read/Write
// pair per byte, with an extra Align cycle when the halt lands on an odd
// parity cycle.
// Ports:
//   i_clk, i_n_reset           : clock, synchronous active-low reset
//   i_cpu_addr/dout/we         : CPU bus request
//   o_cpu_rdy                  : 1 = CPU may advance
//   o_bus_addr/dout/we         : shared system bus drive
//   i_bus_din                  : shared system bus read data
//   o_dma_busy                 : 1 while the DMA owns the bus
//   o_parity                   : free-running cycle parity, exported for reuse
module oam_dma_arbiter
   import typepkg::*;
(
   input  logic        i_clk,
   input  logic        i_n_reset,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_dout,
   input  logic        i_cpu_we,
   output logic        o_cpu_rdy,
   output logic [15:0] o_bus_addr,
   output logic [7:0]  o_bus_dout,
   output logic        o_bus_we,
   input  logic [7:0]  i_bus_din,
   output logic        o_dma_busy,
   output logic        o_parity
);

   dma_state_t r_state;
   logic [7:0] r_page;
   logic [7:0] r_cnt;
   logic [7:0] r_data;
   logic       r_parity;

   logic       w_trig;
   logic       w_idle;

   assign w_trig   = i_cpu_we && (i_cpu_addr == DMA_TRIG_ADDR);
   // Reset forces Idle outputs immediately, so an aborted transfer cannot
   // emit another write strobe in the reset cycle itself.
   assign w_idle   = (r_state == ST_IDLE) || !i_n_reset;
   assign o_parity = r_parity;

   always_ff @(posedge i_clk) begin
      if (!i_n_reset) begin
         r_state  <= ST_IDLE;
         r_page   <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_parity <= 1'b0;
      end else begin
         r_parity <= ~r_parity;
         case (r_state)
            ST_IDLE: begin
               if (w_trig) begin
                  r_page  <= i_cpu_dout;
                  r_cnt   <= '0;
                  r_state <= ST_HALT;
               end
            end
            ST_HALT:  r_state <= r_parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: r_state <= ST_READ;
            ST_READ: begin
               r_data  <= i_bus_din;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               r_cnt   <= r_cnt + 8'd1;
               r_state <= (r_cnt == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_cpu_rdy  = 1'b1;
      o_dma_busy = 1'b0;
      o_bus_addr = i_cpu_addr;
      o_bus_dout = i_cpu_dout;
      o_bus_we   = i_cpu_we;
      if (!w_idle) begin
         o_cpu_rdy  = 1'b0;
         o_dma_busy = 1'b1;
         o_bus_we   = 1'b0;
         case (r_state)
            ST_READ: begin
               o_bus_addr = {r_page, r_cnt};
               o_bus_dout = r_data;
            end
            ST_WRITE: begin
               o_bus_addr = OAM_DATA_ADDR;
               o_bus_dout = r_data;
               o_bus_we   = 1'b1;
            end
            default: begin
               o_bus_addr = i_cpu_addr;
               o_bus_dout = i_cpu_dout;
            end
         endcase
      end
   end

endmodule
